apb_regbank_slave: RTL and testbench

- APB target on the b-side of the asynchronous bridge. It consumes the b_psel/b_penable/b_paddr/b_pwdata/b_pstrb/b_pprot stream the bridge produces and returns b_prdata/b_pready.
- Address space is four regions selected by paddr MSBs; each region has its own wait-state count and access policy.
- Serves as the standard register-bank endpoint behind the bridge, and as the bridge's system-level bench target.

---
 rtl/apb_regbank_slave_pkg.sv | 43 ++++
 rtl/apb_regbank_slave_strb_reg.sv | 21 ++
 rtl/apb_regbank_slave.sv | 129 ++++++++++++
 tb/tb_apb_regbank_slave.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_regbank_slave_pkg.sv
// Shared definitions for the APB register-bank target: region codes, FSM
// encoding, per-region wait lookup and byte-lane merge helper.
package apb_regbank_slave_pkg;

  localparam logic [1:0] R_FAST  = 2'd0;
  localparam logic [1:0] R_SLOW1 = 2'd1;
  localparam logic [1:0] R_SLOW2 = 2'd2;
  localparam logic [1:0] R_ID    = 2'd3;

  // Widest data/strobe the lane-merge helper handles; callers zero-extend.
  localparam int MAX_DW = 64;
  localparam int MAX_SW = 8;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  function automatic int unsigned region_wait(input logic [1:0] region,
                                              input int unsigned wait1,
                                              input int unsigned wait2);
    case (region)
      R_SLOW1: return wait1;
      R_SLOW2: return wait2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [MAX_DW-1:0] lane_merge(input logic [MAX_DW-1:0] old_v,
                                                   input logic [MAX_DW-1:0] new_v,
                                                   input logic [MAX_SW-1:0] strb,
                                                   input int lane_wd);
    logic [MAX_DW-1:0] merged;
    int lane;
    merged = old_v;
    for (int i = 0; i < MAX_DW; i++) begin
      lane = i / lane_wd;
      if (lane < MAX_SW && strb[lane[2:0]]) merged[i] = new_v[i];
    end
    return merged;
  endfunction

endpackage

// File: rtl/apb_regbank_slave_strb_reg.sv
// One data register whose byte lanes are individually write-enabled.
module apb_strb_reg #(
  parameter int DATA_WD = 32,
  parameter int STRB_WD = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [STRB_WD-1:0] strb,
  input  logic [DATA_WD-1:0] wdata,
  output logic [DATA_WD-1:0] q
);
  import apb_regbank_slave_pkg::*;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else if (we)
      q <= DATA_WD'(lane_merge(MAX_DW'(q), MAX_DW'(wdata), MAX_SW'(strb), DATA_WD / STRB_WD));
  end

endmodule

// File: rtl/apb_regbank_slave.sv
// APB register-bank target: four address regions with per-region wait states,
// a privileged-write region and a read-only ID region.
module apb_regbank_slave #(
  parameter int ADDR_WD = 8,
  parameter int DATA_WD = 32,
  parameter int STRB_WD = 2,
  parameter int PROT_WD = 4,
  parameter int REG_AW  = 2,
  parameter int WAIT1   = 1,
  parameter int WAIT2   = 3,
  parameter logic [DATA_WD-1:0] ID_VALUE = 32'hA5B0_0000
) (
  input  logic               b_pclk,
  input  logic               b_prst,
  input  logic               b_psel,
  input  logic               b_penable,
  input  logic               b_pwrite,
  input  logic [ADDR_WD-1:0] b_paddr,
  input  logic [DATA_WD-1:0] b_pwdata,
  input  logic [PROT_WD-1:0] b_pprot,
  input  logic [STRB_WD-1:0] b_pstrb,
  output logic [DATA_WD-1:0] b_prdata,
  output logic               b_pready,
  output logic               prot_err
);
  import apb_regbank_slave_pkg::*;

  localparam int WMAX = (WAIT1 > WAIT2) ? WAIT1 : WAIT2;
  localparam int CW   = (WMAX > 0) ? $clog2(WMAX + 1) : 1;
  localparam int NREG = 1 << REG_AW;

  // Handshake: a transfer is SETUP (psel & ~penable) for one cycle, then ACCESS
  // (psel & penable) until pready; pready is high for exactly one cycle.
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        region_q, region_d;
  logic [REG_AW-1:0] index_q, index_d;
  logic              write_q, write_d;
  logic              err_d;
  logic              commit_we;
  logic [DATA_WD-1:0] rd_data;
  logic [DATA_WD-1:0] reg_q [4*NREG];
  logic              unused_bits;

  assign unused_bits = ^{b_pprot[PROT_WD-1:1], b_paddr[ADDR_WD-3:REG_AW]};

  always_ff @(posedge b_pclk or posedge b_prst) begin
    if (b_prst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      region_q <= R_FAST;
      index_q  <= '0;
      write_q  <= 1'b0;
      prot_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      region_q <= region_d;
      index_q  <= index_d;
      write_q  <= write_d;
      prot_err <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    region_d = region_q;
    index_d  = index_q;
    write_d  = write_q;
    err_d    = prot_err;
    case (state_q)
      S_IDLE: begin
        if (b_psel && !b_penable) begin
          region_d = b_paddr[ADDR_WD-1:ADDR_WD-2];
          index_d  = b_paddr[REG_AW-1:0];
          write_d  = b_pwrite;
          cnt_d    = CW'(region_wait(b_paddr[ADDR_WD-1:ADDR_WD-2], WAIT1, WAIT2));
          state_d  = S_ACCESS;
        end else if (b_psel && b_penable) begin
          err_d = 1'b1;
        end
      end
      S_ACCESS: begin
        if (!b_psel) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign b_pready = (state_q == S_ACCESS) && (cnt_q == '0) && b_psel;

  // Region 2 only accepts privileged writes; region 3 is constant.
  assign commit_we = b_pready && write_q && (region_q != R_ID) &&
                     ((region_q != R_SLOW2) || b_pprot[0]);

  for (genvar r = 0; r < 4; r++) begin : g_region
    for (genvar i = 0; i < NREG; i++) begin : g_idx
      if (r == 3) begin : g_ro
        assign reg_q[r*NREG+i] = '0;
      end else begin : g_rw
        apb_strb_reg #(.DATA_WD(DATA_WD), .STRB_WD(STRB_WD)) u_reg (
          .clk   (b_pclk),
          .rst   (b_prst),
          .we    (commit_we && (region_q == 2'(r)) && (index_q == REG_AW'(i))),
          .strb  (b_pstrb),
          .wdata (b_pwdata),
          .q     (reg_q[r*NREG+i])
        );
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (region_q == R_ID) rd_data = ID_VALUE | DATA_WD'({region_q, index_q});
    else                  rd_data = reg_q[{region_q, index_q}];
  end

  assign b_prdata = (b_pready && !write_q) ? rd_data : '0;

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Directed and randomized APB transfers against a register-map reference model.
module tb_apb_regbank_slave;

  logic        b_pclk = 1'b0;
  logic        b_prst;
  logic        b_psel, b_penable, b_pwrite;
  logic [7:0]  b_paddr;
  logic [31:0] b_pwdata;
  logic [3:0]  b_pprot;
  logic [1:0]  b_pstrb;
  logic [31:0] b_prdata;
  logic        b_pready;
  logic        prot_err;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [3][4];

  // ---------------- clock / reset ----------------
  always #5 b_pclk = ~b_pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  apb_regbank_slave dut (
    .b_pclk    (b_pclk),
    .b_prst    (b_prst),
    .b_psel    (b_psel),
    .b_penable (b_penable),
    .b_pwrite  (b_pwrite),
    .b_paddr   (b_paddr),
    .b_pwdata  (b_pwdata),
    .b_pprot   (b_pprot),
    .b_pstrb   (b_pstrb),
    .b_prdata  (b_prdata),
    .b_pready  (b_pready),
    .prot_err  (prot_err)
  );

  // ---------------- reference model ----------------
  function automatic int model_wait(input logic [7:0] addr);
    case (addr[7:6])
      2'd1:    return 1;
      2'd2:    return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] addr);
    int r = int'(addr[7:6]);
    int i = int'(addr[1:0]);
    if (r == 3) return 32'hA5B0_0000 + 32'(r * 4 + i);
    return mem[r][i];
  endfunction

  task automatic model_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [1:0] strb, input logic [3:0] prot);
    int r = int'(addr[7:6]);
    int i = int'(addr[1:0]);
    if (r == 3) return;
    if (r == 2 && !prot[0]) return;
    for (int k = 0; k < 2; k++)
      if (strb[k]) mem[r][i][k*16 +: 16] = data[k*16 +: 16];
  endtask

  task automatic model_clear();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) mem[r][i] = '0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic bus_idle();
    @(negedge b_pclk);
    b_psel = 1'b0; b_penable = 1'b0;
  endtask

  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [1:0] strb, input logic [3:0] prot,
                          output logic [31:0] rdata, output int waits);
    int n;
    @(negedge b_pclk);
    b_psel = 1'b1; b_penable = 1'b0; b_pwrite = wr; b_paddr = addr;
    b_pwdata = wdata; b_pstrb = strb; b_pprot = prot;
    #1;
    check("setup_pready", 32'(b_pready), 32'd0);
    @(negedge b_pclk);
    b_penable = 1'b1;
    #1;
    n = 0;
    while (!b_pready && n < 20) begin
      @(negedge b_pclk);
      #1;
      n++;
    end
    check("pready_seen", 32'(b_pready), 32'd1);
    rdata = b_prdata;
    waits = n;
    if (!b_pready) bus_idle();
  endtask

  // Transfer plus scoreboard update; returns the observed read data.
  task automatic run(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                     input logic [1:0] strb, input logic [3:0] prot,
                     output logic [31:0] rdata);
    int waits;
    exp_q.push_back(wr ? 32'd0 : model_read(addr));
    apb_xfer(wr, addr, wdata, strb, prot, rdata, waits);
    check($sformatf("waits@%h", addr), 32'(waits), 32'(model_wait(addr)));
    check($sformatf("prdata@%h", addr), rdata, exp_q.pop_front());
    if (wr) model_write(addr, wdata, strb, prot);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        wr;
    logic [7:0]  addr;
    b_prst = 1'b1; b_psel = 1'b0; b_penable = 1'b0; b_pwrite = 1'b0;
    b_paddr = '0; b_pwdata = '0; b_pprot = '0; b_pstrb = '0;
    model_clear();
    #1;
    check("rst_pready", 32'(b_pready), 32'd0);
    check("rst_prdata", b_prdata, 32'd0);
    check("rst_prot_err", 32'(prot_err), 32'd0);
    @(negedge b_pclk); @(negedge b_pclk);
    b_prst = 1'b0;

    // Region 0: zero waits, back-to-back write then read
    run(1'b1, 8'h3F, 32'h0000_FFFF, 2'b11, 4'h0, rd);
    run(1'b0, 8'h3F, 32'h0, 2'b00, 4'h0, rd);
    check("r0_read", rd, 32'h0000_FFFF);

    // Region 1: one wait, lane strobes
    run(1'b1, 8'h7F, 32'hFFFF_0000, 2'b01, 4'h0, rd);
    run(1'b0, 8'h7F, 32'h0, 2'b00, 4'h0, rd);
    check("r1_lane0", rd, 32'h0000_0000);
    run(1'b1, 8'h7F, 32'hFFFF_0000, 2'b10, 4'h0, rd);
    bus_idle();
    run(1'b0, 8'h7F, 32'h0, 2'b00, 4'h0, rd);
    check("r1_lane1", rd, 32'hFFFF_0000);

    // Region 2: three waits, privileged writes only
    run(1'b1, 8'h81, 32'h1234_5678, 2'b11, 4'h0, rd);
    run(1'b0, 8'h81, 32'h0, 2'b00, 4'h0, rd);
    check("r2_unpriv", rd, 32'h0);
    run(1'b1, 8'h81, 32'h1234_5678, 2'b11, 4'h1, rd);
    run(1'b0, 8'h81, 32'h0, 2'b00, 4'h0, rd);
    check("r2_priv", rd, 32'h1234_5678);

    // Region 3: read-only ID, aliasing of middle address bits
    run(1'b1, 8'hC2, 32'hFFFF_FFFF, 2'b11, 4'h1, rd);
    run(1'b0, 8'hC2, 32'h0, 2'b00, 4'h0, rd);
    check("r3_id", rd, 32'hA5B0_000E);
    run(1'b0, 8'h8D, 32'h0, 2'b00, 4'h0, rd);
    check("r2_alias", rd, 32'h1234_5678);
    bus_idle();
    check("no_err_yet", 32'(prot_err), 32'd0);

    // ACCESS without SETUP
    @(negedge b_pclk);
    b_psel = 1'b1; b_penable = 1'b1; b_pwrite = 1'b1; b_paddr = 8'h3F;
    b_pwdata = 32'hDEAD_BEEF; b_pstrb = 2'b11;
    #1;
    check("nosetup_pready", 32'(b_pready), 32'd0);
    bus_idle();
    #1;
    check("nosetup_err", 32'(prot_err), 32'd1);
    run(1'b0, 8'h3F, 32'h0, 2'b00, 4'h0, rd);
    check("nosetup_nowrite", rd, 32'h0000_FFFF);
    bus_idle();

    // Reset pulse clears flag and registers
    @(negedge b_pclk); b_prst = 1'b1;
    @(negedge b_pclk); b_prst = 1'b0;
    model_clear();
    #1;
    check("pulse_err_clr", 32'(prot_err), 32'd0);

    // Master abort during region-2 waits
    @(negedge b_pclk);
    b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b1; b_paddr = 8'h82;
    b_pwdata = 32'hCAFE_F00D; b_pstrb = 2'b11; b_pprot = 4'h1;
    @(negedge b_pclk);
    b_penable = 1'b1;
    #1;
    check("abort_wait", 32'(b_pready), 32'd0);
    bus_idle();
    @(negedge b_pclk);
    #1;
    check("abort_err", 32'(prot_err), 32'd1);
    run(1'b0, 8'h82, 32'h0, 2'b00, 4'h0, rd);
    check("abort_nowrite", rd, 32'h0);
    run(1'b1, 8'h43, 32'h5555_AAAA, 2'b11, 4'h0, rd);
    run(1'b0, 8'h43, 32'h0, 2'b00, 4'h0, rd);
    check("after_abort", rd, 32'h5555_AAAA);

    // Reset asserted during a region-2 write wait
    @(negedge b_pclk);
    b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b1; b_paddr = 8'h81;
    b_pwdata = 32'hDEAD_BEEF; b_pstrb = 2'b11; b_pprot = 4'h1;
    @(negedge b_pclk);
    b_penable = 1'b1;
    @(negedge b_pclk);
    b_prst = 1'b1;
    #1;
    check("rstwait_pready", 32'(b_pready), 32'd0);
    check("rstwait_prdata", b_prdata, 32'd0);
    check("rstwait_err", 32'(prot_err), 32'd0);
    @(negedge b_pclk);
    b_prst = 1'b0; b_psel = 1'b0; b_penable = 1'b0;
    model_clear();
    run(1'b0, 8'h81, 32'h0, 2'b00, 4'h0, rd);
    check("rstwait_reg", rd, 32'h0);
    run(1'b0, 8'h43, 32'h0, 2'b00, 4'h0, rd);
    check("rstwait_r1", rd, 32'h0);

    // Randomized traffic against the model
    for (int t = 0; t < 300; t++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 8'($urandom_range(0, 255));
      run(wr, addr, $urandom, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), rd);
      if ($urandom_range(0, 2) == 0) bus_idle();
    end
    bus_idle();
    check("final_err", 32'(prot_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
